fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries buffered (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request, level, held until acknowledged.
REQ-006 imem_addr  output  32  word-aligned read address, valid while imem_req=1.
REQ-007 imem_ack  input  1  memory response strobe; imem_rdata valid in same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  one-cycle pulse: branch/jump taken, flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 out_valid  output  1  head entry available to decoder.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  32  address of head instruction.
REQ-014 out_ready  input  1  decoder accepts head this cycle.
REQ-015 count  output  $clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-016 Queue SHALL be a FIFO of {pc, instr} pairs; pop when out_valid && out_ready; push on accepted imem_ack.
REQ-017 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL be 0 when out_valid=0.
REQ-018 Fetch FSM SHALL have states IDLE, WAIT, DRAIN; imem_req=1 exactly in WAIT and DRAIN.
REQ-019 IDLE -> WAIT on next edge when count < DEPTH (after that edge's pop/push) or when redirect=1.
REQ-020 WAIT with imem_ack=1 and redirect=0: push {fetch_pc, imem_rdata}, fetch_pc += 4; stay WAIT if post-update count < DEPTH, else IDLE.
REQ-021 WAIT with imem_ack=0 and redirect=1: go DRAIN; imem_addr SHALL remain the old address until ack.
REQ-022 WAIT with imem_ack=1 and redirect=1: discard imem_rdata, go WAIT with imem_addr=redirect_pc.
REQ-023 DRAIN: imem_ack discards the response and moves to WAIT with the redirected fetch_pc; redirect during DRAIN only updates fetch_pc.
REQ-024 Any redirect SHALL empty the queue (count=0) on that edge, overriding same-cycle push and pop.
REQ-025 imem_addr SHALL be stable while imem_req=1 and not acknowledged; at most one request outstanding.
REQ-026 imem_ack with imem_req=0 SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; push SHALL never occur when count=DEPTH (guaranteed by REQ-019/020).
REQ-028 fetch_pc and redirect_pc bits [1:0] SHALL be forced to 00; fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 Latency: imem_ack in cycle N -> out_valid=1 in cycle N+1 with that entry at head if queue was empty.
REQ-030 Sustained throughput SHALL be one instruction per cycle when memory acks every cycle and out_ready=1.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, count=0, out_valid=0, out_instr=0, out_pc=0, imem_req=0, fetch_pc=imem_addr=RESET_PC.
REQ-032 Reset asserted mid-request SHALL abandon the outstanding request; a later imem_ack SHALL be ignored (REQ-026).
REQ-033 First imem_req SHALL assert on the first rising edge after reset deasserts.

Verification
REQ-034 Reset release, ack every cycle with rdata=addr^32'hA5A5_0000, out_ready=1 -> out_pc 0,4,8,... one per cycle, out_instr matching.
REQ-035 out_ready=0, ack every cycle, DEPTH=4 -> count reaches 4, imem_req drops, no fifth push; out_ready=1 -> entries 0,4,8,C in order, fetching resumes at 0x10.
REQ-036 Redirect to 0x200 while in WAIT with ack delayed 3 cycles -> DRAIN holds old addr, response discarded, next request addr 0x200, queue empty until its ack.
REQ-037 Redirect to 0x80 in same cycle as ack and pop -> count=0, data dropped, next imem_addr=0x80.
REQ-038 redirect_pc=32'hFFFF_FFFE -> fetch addresses FFFF_FFFC then 0000_0000.
REQ-039 reset asserted with request outstanding, ack arrives during reset -> no push, all outputs at REQ-031 values.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bundles the fetch queue's instruction-memory, redirect and decoder-side signals.
// master = fetch_queue, slave = memory/decoder environment.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          out_ready;
    logic [CW-1:0] count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetch FSM feeding a {pc, instr} FIFO,
// flushed and refetched on redirect.
//
// state    | meaning
// ST_IDLE  | no request outstanding (queue full, or just out of reset)
// ST_WAIT  | request outstanding, response will be pushed
// ST_DRAIN | request outstanding for a redirected-away address, response discarded
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [31:0]   PC_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0]   RESET_PC_A = RESET_PC & PC_MASK;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

    state_t        state;
    logic          req;
    logic [31:0]   req_addr;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          push;
    logic          pop;
    logic          flush;
    logic [31:0]   redir_pc;
    logic          head_valid;

    always_comb begin
        flush      = bus.redirect;
        redir_pc   = bus.redirect_pc & PC_MASK;
        head_valid = (count_q != '0);
        push       = (state == ST_WAIT) && bus.imem_ack && !flush;
        pop        = head_valid && bus.out_ready;
        count_nxt  = flush ? '0
                           : count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            req      <= 1'b0;
            req_addr <= RESET_PC_A;
            fetch_pc <= RESET_PC_A;
            count_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            count_q <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state    <= ST_WAIT;
                        req      <= 1'b1;
                        req_addr <= redir_pc;
                        fetch_pc <= redir_pc;
                    end else if (count_nxt < FULL) begin
                        state    <= ST_WAIT;
                        req      <= 1'b1;
                        req_addr <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_ack && flush) begin
                        req_addr <= redir_pc;
                        fetch_pc <= redir_pc;
                    end else if (bus.imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        req_addr <= fetch_pc + 32'd4;
                        if (count_nxt >= FULL) begin
                            state <= ST_IDLE;
                            req   <= 1'b0;
                        end
                    end else if (flush) begin
                        // old address stays on the bus until its response comes back
                        state    <= ST_DRAIN;
                        fetch_pc <= redir_pc;
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_ack) begin
                        state    <= ST_WAIT;
                        req_addr <= flush ? redir_pc : fetch_pc;
                        if (flush) fetch_pc <= redir_pc;
                    end else if (flush) begin
                        fetch_pc <= redir_pc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = req_addr;
    assign bus.count     = count_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign bus.out_instr = head_valid ? instr_mem[rd_ptr] : 32'h0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0): streaming, fill-to-full, redirects,
// address wrap and reset during an outstanding request.
module tb_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.DEPTH(4)) bus();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_pc"}, bus.out_pc, pc);
        chk({tag, "_instr"}, bus.out_instr, pc ^ K);
    endtask

    task automatic exp_empty(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_pc"}, bus.out_pc, 32'd0);
        chk({tag, "_instr"}, bus.out_instr, 32'd0);
    endtask

    task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'(req));
        if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        reset           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b0;

        // reset values
        #2;
        exp_empty("rst");
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);

        // streaming: ack every cycle, pop every cycle
        #10;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_req("stream", 1'b1, 32'(4 * i));
            if (i == 0) begin
                exp_empty("stream_first");
            end else begin
                exp_head("stream", 32'(4 * (i - 1)));
                chk("stream_count", 32'(bus.count), 32'd1);
            end
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'(4 * i) ^ K;
            tick();
        end
        exp_head("stream_last", 32'd20);
        exp_req("stream_last", 1'b1, 32'd24);

        // reset with a request outstanding; ack during reset is ignored
        bus.imem_ack = 1'b0;
        reset        = 1'b0;
        #1;
        exp_empty("rst_mid");
        chk("rst_mid_req", 32'(bus.imem_req), 32'd0);
        chk("rst_mid_addr", bus.imem_addr, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        exp_empty("rst_ack");
        chk("rst_ack_req", 32'(bus.imem_req), 32'd0);
        chk("rst_ack_addr", bus.imem_addr, 32'h0);

        // fill to DEPTH with decoder stalled
        bus.imem_ack  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        tick();
        exp_req("fill_start", 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_req("fill", 1'b1, 32'(4 * i));
            chk("fill_count", 32'(bus.count), 32'(i));
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'(4 * i) ^ K;
            tick();
        end
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_req", 32'(bus.imem_req), 32'd0);
        exp_head("full", 32'h0);
        tick();
        chk("full_hold_count", 32'(bus.count), 32'd4);
        chk("full_hold_req", 32'(bus.imem_req), 32'd0);
        exp_head("full_hold", 32'h0);

        // drain in order; fetching resumes at 0x10
        bus.imem_ack  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        exp_head("drain1", 32'h4);
        chk("drain1_count", 32'(bus.count), 32'd3);
        exp_req("drain1", 1'b1, 32'h10);
        tick();
        exp_head("drain2", 32'h8);
        chk("drain2_count", 32'(bus.count), 32'd2);
        tick();
        exp_head("drain3", 32'hC);
        chk("drain3_count", 32'(bus.count), 32'd1);
        tick();
        exp_empty("drained");
        exp_req("drained", 1'b1, 32'h10);

        // redirect while waiting, response delayed: DRAIN holds old address
        bus.out_ready  = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h10 ^ K;
        tick();
        exp_head("pre_redir", 32'h10);
        exp_req("pre_redir", 1'b1, 32'h14);
        bus.imem_ack    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect = 1'b0;
        exp_empty("drain_st");
        exp_req("drain_st", 1'b1, 32'h14);
        tick();
        exp_req("drain_hold1", 1'b1, 32'h14);
        tick();
        exp_req("drain_hold2", 1'b1, 32'h14);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h14 ^ K;
        tick();
        bus.imem_ack = 1'b0;
        exp_empty("drain_discard");
        exp_req("redir_addr", 1'b1, 32'h200);
        tick();
        exp_empty("redir_wait");
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h200 ^ K;
        bus.out_ready  = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        exp_head("redir_push", 32'h200);
        chk("redir_push_count", 32'(bus.count), 32'd1);
        exp_req("redir_push", 1'b1, 32'h204);

        // redirect together with ack and pop
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h204 ^ K;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;
        exp_empty("redir_ack");
        exp_req("redir_ack", 1'b1, 32'h80);

        // misaligned redirect target and address wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        tick();
        bus.redirect = 1'b0;
        exp_req("wrap_drain", 1'b1, 32'h80);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        tick();
        exp_empty("wrap_discard");
        exp_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
        bus.imem_rdata = 32'hFFFF_FFFC ^ K;
        tick();
        exp_head("wrap_top", 32'hFFFF_FFFC);
        exp_req("wrap_zero", 1'b1, 32'h0);
        bus.imem_rdata = 32'h0 ^ K;
        tick();
        bus.imem_ack = 1'b0;
        exp_head("wrap_zero", 32'h0);
        chk("wrap_count", 32'(bus.count), 32'd1);
        exp_req("wrap_next", 1'b1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
